// File: rtl/avalon_master_bridge.sv
// avalon_master_bridge: sequences each CPU step as an optional sized data access
// followed by an instruction fetch on a single Avalon-MM master port.
// Every Avalon-side and CPU-side output is registered.
// Optional build macro AVB_TIMEOUT_EN: abort an access after MAX_WAIT
// waitrequest-high cycles and report it as a bus error.
module avalon_master_bridge #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   instr_address,
    output logic [DATA_W-1:0]   instr_readdata,
    input  logic [ADDR_W-1:0]   data_address,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [1:0]          data_size,
    input  logic [DATA_W-1:0]   data_writedata,
    output logic [DATA_W-1:0]   data_readdata,
    output logic                clk_enable,
    output logic                bus_error,
    output logic [ADDR_W-1:0]   av_address,
    output logic                av_read,
    output logic                av_write,
    input  logic                av_waitrequest,
    output logic [DATA_W-1:0]   av_writedata,
    output logic [DATA_W/8-1:0] av_byteenable,
    input  logic [DATA_W-1:0]   av_readdata
);
    localparam int BE_W = DATA_W / 8;
    localparam int LB   = $clog2(BE_W);

    if ((DATA_W != 32 && DATA_W != 64) || MAX_WAIT < 1) begin : g_bad_param
        $error("avalon_master_bridge: DATA_W must be 32 or 64 and MAX_WAIT at least 1");
    end

    typedef enum logic [1:0] {IDLE, DATA, INSTR, STEP} state_t;
    state_t state_reg, state_next;

    logic [LB-1:0]     lane;
    logic              req_one, req_any, size_ok, misaligned, go_data, skip_err;
    logic              done, timeout_hit, err_pending_reg;
    logic [DATA_W-1:0] rd_extract;
    logic [ADDR_W-1:0] av_address_next;
    logic              av_read_next, av_write_next, clk_enable_next, bus_error_next;
    logic [DATA_W-1:0] av_writedata_next;
    logic [BE_W-1:0]   av_byteenable_next;
    logic              unused_instr_lane;

    // Byte-lane mask covering 2^size bytes starting at lane 0.
    function automatic logic [BE_W-1:0] size_be(input logic [1:0] size);
        logic [BE_W-1:0] m;
        for (int i = 0; i < BE_W; i++) m[i] = (i < (1 << size));
        return m;
    endfunction

    // Bit mask covering 8*2^size data bits starting at bit 0.
    function automatic logic [DATA_W-1:0] size_dmask(input logic [1:0] size);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < DATA_W; i++) m[i] = (i < (8 << size));
        return m;
    endfunction

    // Fetches are always whole bus words, so the low instruction address bits are dropped.
    assign unused_instr_lane = &{1'b0, instr_address[LB-1:0]};

    assign lane       = data_address[LB-1:0];
    assign req_one    = data_read ^ data_write;
    assign req_any    = data_read | data_write;
    assign size_ok    = (data_size != 2'd3) || (DATA_W == 64);
    assign go_data    = req_one && size_ok && !misaligned;
    assign skip_err   = req_any && !go_data;
    assign rd_extract = (av_readdata >> {lane, 3'b000}) & size_dmask(data_size);
    assign done       = !av_waitrequest || timeout_hit;

    // Natural alignment check: the address must be a multiple of the access size.
    always_comb begin
        case (data_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = data_address[0];
            2'd2:    misaligned = |data_address[1:0];
            default: misaligned = |data_address[2:0];
        endcase
    end

`ifdef AVB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt_reg;

    // The abort lands on the edge that ends the MAX_WAIT-th stalled cycle.
    assign timeout_hit = (state_reg == DATA || state_reg == INSTR) && av_waitrequest
                         && (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1));

    // Count stalled cycles; restart at every state change so each access gets a fresh budget.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     wait_cnt_reg <= '0;
        else if (state_next != state_reg) wait_cnt_reg <= '0;
        else if (av_waitrequest)          wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state decode: optional data access, then fetch, then one advance cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = go_data ? DATA : INSTR;
            DATA:    if (done) state_next = INSTR;
            INSTR:   if (done) state_next = STEP;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the registered outputs line up with it.
    always_comb begin
        av_address_next    = '0;
        av_read_next       = 1'b0;
        av_write_next      = 1'b0;
        av_writedata_next  = '0;
        av_byteenable_next = '0;
        clk_enable_next    = (state_next == STEP);
        bus_error_next     = (state_next == STEP) && (err_pending_reg || timeout_hit);
        case (state_next)
            DATA: begin
                av_address_next    = {data_address[ADDR_W-1:LB], {LB{1'b0}}};
                av_read_next       = data_read;
                av_write_next      = data_write;
                av_byteenable_next = size_be(data_size) << lane;
                av_writedata_next  = data_write ? (data_writedata << {lane, 3'b000}) : '0;
            end
            INSTR: begin
                av_address_next    = {instr_address[ADDR_W-1:LB], {LB{1'b0}}};
                av_read_next       = 1'b1;
                av_byteenable_next = '1;
            end
            default: ;
        endcase
    end

    // Output registers, read-data capture and the pending-error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            av_address      <= '0;
            av_read         <= 1'b0;
            av_write        <= 1'b0;
            av_writedata    <= '0;
            av_byteenable   <= '0;
            clk_enable      <= 1'b0;
            bus_error       <= 1'b0;
            data_readdata   <= '0;
            instr_readdata  <= '0;
            err_pending_reg <= 1'b0;
        end else begin
            av_address    <= av_address_next;
            av_read       <= av_read_next;
            av_write      <= av_write_next;
            av_writedata  <= av_writedata_next;
            av_byteenable <= av_byteenable_next;
            clk_enable    <= clk_enable_next;
            bus_error     <= bus_error_next;
            if (state_reg == IDLE && skip_err && data_read)
                data_readdata <= '0;
            if (state_reg == DATA && done && data_read)
                data_readdata <= timeout_hit ? '0 : rd_extract;
            if (state_reg == INSTR && done)
                instr_readdata <= timeout_hit ? '0 : av_readdata;
            if (state_next == STEP)
                err_pending_reg <= 1'b0;
            else if ((state_reg == IDLE && skip_err) || timeout_hit)
                err_pending_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_avalon_master_bridge.sv
// Directed bench for avalon_master_bridge: each task drives one CPU step scenario
// against a small Avalon slave behaviour and compares with hand-computed values.
module tb_avalon_master_bridge;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr_address = '0, instr_readdata;
    logic [31:0] data_address = '0, data_writedata = '0, data_readdata;
    logic        data_read = 1'b0, data_write = 1'b0;
    logic [1:0]  data_size = '0;
    logic        clk_enable, bus_error;
    logic [31:0] av_address, av_writedata;
    logic        av_read, av_write;
    logic        av_waitrequest = 1'b0;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata = '0;

`ifdef AVB_TIMEOUT_EN
    localparam int FETCH_WAITS = 3;
`else
    localparam int FETCH_WAITS = 5;
`endif

    int checks = 0;
    int passes = 0;

    // Observations of the most recent CPU step.
    int          obs_cycles, obs_xfers, obs_ce;
    logic        obs_err, obs_stable;
    logic [31:0] obs_addr [2];
    logic [31:0] obs_wdata [2];
    logic [3:0]  obs_be [2];
    logic        obs_rd [2];
    logic        obs_wr [2];

    avalon_master_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_size(data_size), .data_writedata(data_writedata), .data_readdata(data_readdata),
        .clk_enable(clk_enable), .bus_error(bus_error),
        .av_address(av_address), .av_read(av_read), .av_write(av_write),
        .av_waitrequest(av_waitrequest), .av_writedata(av_writedata),
        .av_byteenable(av_byteenable), .av_readdata(av_readdata)
    );

    always #5 clk = ~clk;

    // Present one request starting in IDLE and play the slave until clk_enable.
    // Every transfer is stalled for 'waits' cycles; rd0/rd1 answer the first/second transfer.
    task automatic run_step(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic [31:0] daddr, input logic [31:0] wdata,
                            input logic [31:0] iaddr, input logic [31:0] rd0,
                            input logic [31:0] rd1, input int waits);
        int          wait_left, idx;
        logic        prev_wait, p_rd, p_wr;
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_be;
        data_read = rd; data_write = wr; data_size = sz; data_address = daddr;
        data_writedata = wdata; instr_address = iaddr;
        obs_cycles = -1; obs_ce = 0; obs_err = 1'b0; obs_stable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            obs_addr[k] = '0; obs_wdata[k] = '0; obs_be[k] = '0; obs_rd[k] = 1'b0; obs_wr[k] = 1'b0;
        end
        wait_left = waits; idx = 0; prev_wait = 1'b0;
        p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0; p_be = '0;
        av_waitrequest = 1'b0; av_readdata = rd0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (prev_wait && (av_address !== p_addr || av_read !== p_rd || av_write !== p_wr
                              || av_byteenable !== p_be || av_writedata !== p_wdata))
                obs_stable = 1'b0;
            av_readdata = (idx == 0) ? rd0 : rd1;
            if (clk_enable) begin
                obs_cycles = c + 1; obs_err = bus_error; obs_ce = 1; av_waitrequest = 1'b0;
                break;
            end
            if (av_read || av_write) begin
                if (wait_left > 0) begin
                    av_waitrequest = 1'b1; wait_left--;
                end else begin
                    av_waitrequest = 1'b0;
                    if (idx < 2) begin
                        obs_addr[idx] = av_address; obs_wdata[idx] = av_writedata;
                        obs_be[idx] = av_byteenable; obs_rd[idx] = av_read; obs_wr[idx] = av_write;
                    end
                    idx++; wait_left = waits;
                end
            end else begin
                av_waitrequest = 1'b0;
            end
            prev_wait = av_waitrequest;
            p_addr = av_address; p_rd = av_read; p_wr = av_write; p_be = av_byteenable; p_wdata = av_writedata;
        end
        obs_xfers = idx;
        @(negedge clk);
        if (clk_enable) obs_ce++;
        av_waitrequest = 1'b0;
        $display("step rd=%0b wr=%0b size=%0d daddr=%h iaddr=%h: cycles=%0d transfers=%0d bus_error=%0b rdata=%h instr=%h",
                 rd, wr, sz, daddr, iaddr, obs_cycles, obs_xfers, obs_err, data_readdata, instr_readdata);
    endtask

    task automatic test_reset;
        checks++; if (av_read !== 1'b0) $display("FAIL reset_av_read got %b exp 0", av_read); else passes++;
        checks++; if (av_write !== 1'b0) $display("FAIL reset_av_write got %b exp 0", av_write); else passes++;
        checks++; if (clk_enable !== 1'b0) $display("FAIL reset_clk_enable got %b exp 0", clk_enable); else passes++;
        checks++; if (av_byteenable !== 4'h0) $display("FAIL reset_byteenable got %h exp 0", av_byteenable); else passes++;
        checks++; if (av_address !== 32'h0) $display("FAIL reset_av_address got %h exp 0", av_address); else passes++;
    endtask

    task automatic test_word_read;
        run_step(1'b1, 1'b0, 2'd2, 32'h104, 32'h0, 32'h1000, 32'hDEADBEEF, 32'h13579BDF, 0);
        checks++; if (obs_cycles !== 4) $display("FAIL word_rd_cycles got %0d exp 4", obs_cycles); else passes++;
        checks++; if (obs_xfers !== 2) $display("FAIL word_rd_xfers got %0d exp 2", obs_xfers); else passes++;
        checks++; if (obs_addr[0] !== 32'h104) $display("FAIL word_rd_addr got %h exp 104", obs_addr[0]); else passes++;
        checks++; if (obs_be[0] !== 4'b1111) $display("FAIL word_rd_be got %b exp 1111", obs_be[0]); else passes++;
        checks++; if (obs_rd[0] !== 1'b1 || obs_wr[0] !== 1'b0) $display("FAIL word_rd_dir got rd=%b wr=%b exp rd=1 wr=0", obs_rd[0], obs_wr[0]); else passes++;
        checks++; if (data_readdata !== 32'hDEADBEEF) $display("FAIL word_rd_data got %h exp deadbeef", data_readdata); else passes++;
        checks++; if (obs_addr[1] !== 32'h1000) $display("FAIL word_rd_fetch_addr got %h exp 1000", obs_addr[1]); else passes++;
        checks++; if (instr_readdata !== 32'h13579BDF) $display("FAIL word_rd_instr got %h exp 13579bdf", instr_readdata); else passes++;
        checks++; if (obs_ce !== 1 || obs_err !== 1'b0) $display("FAIL word_rd_strobe got ce=%0d err=%b exp ce=1 err=0", obs_ce, obs_err); else passes++;
    endtask

    task automatic test_byte_write;
        run_step(1'b0, 1'b1, 2'd0, 32'h203, 32'h5A, 32'h1004, 32'hFFFFFFFF, 32'h0BADF00D, 0);
        checks++; if (obs_addr[0] !== 32'h200) $display("FAIL byte_wr_addr got %h exp 200", obs_addr[0]); else passes++;
        checks++; if (obs_be[0] !== 4'b1000) $display("FAIL byte_wr_be got %b exp 1000", obs_be[0]); else passes++;
        checks++; if (obs_wdata[0] !== 32'h5A000000) $display("FAIL byte_wr_wdata got %h exp 5a000000", obs_wdata[0]); else passes++;
        checks++; if (obs_wr[0] !== 1'b1 || obs_rd[0] !== 1'b0) $display("FAIL byte_wr_dir got rd=%b wr=%b exp rd=0 wr=1", obs_rd[0], obs_wr[0]); else passes++;
        checks++; if (obs_addr[1] !== 32'h1004 || obs_be[1] !== 4'hF) $display("FAIL byte_wr_fetch got %h/%b exp 1004/1111", obs_addr[1], obs_be[1]); else passes++;
        checks++; if (obs_ce !== 1 || obs_cycles !== 4) $display("FAIL byte_wr_strobe got ce=%0d cycles=%0d exp 1/4", obs_ce, obs_cycles); else passes++;
        checks++; if (data_readdata !== 32'hDEADBEEF) $display("FAIL byte_wr_keeps_rdata got %h exp deadbeef", data_readdata); else passes++;
        checks++; if (instr_readdata !== 32'h0BADF00D) $display("FAIL byte_wr_instr got %h exp 0badf00d", instr_readdata); else passes++;
    endtask

    task automatic test_sized_read;
        run_step(1'b1, 1'b0, 2'd1, 32'h102, 32'h0, 32'h1008, 32'h1234ABCD, 32'h0, 0);
        checks++; if (data_readdata !== 32'h00001234) $display("FAIL half_rd_data got %h exp 00001234", data_readdata); else passes++;
        checks++; if (obs_addr[0] !== 32'h100 || obs_be[0] !== 4'b1100) $display("FAIL half_rd_bus got %h/%b exp 100/1100", obs_addr[0], obs_be[0]); else passes++;
        run_step(1'b1, 1'b0, 2'd0, 32'h001, 32'h0, 32'h100C, 32'hA1B2C3D4, 32'h0, 0);
        checks++; if (data_readdata !== 32'h000000C3) $display("FAIL byte_rd_data got %h exp 000000c3", data_readdata); else passes++;
        checks++; if (obs_addr[0] !== 32'h0 || obs_be[0] !== 4'b0010) $display("FAIL byte_rd_bus got %h/%b exp 0/0010", obs_addr[0], obs_be[0]); else passes++;
    endtask

    task automatic test_skipped_access;
        // Misaligned half read: fetch only, error pulse, read data cleared.
        run_step(1'b1, 1'b0, 2'd1, 32'h101, 32'h0, 32'h2000, 32'h55556666, 32'h0, 0);
        checks++; if (obs_xfers !== 1 || obs_addr[0] !== 32'h2000) $display("FAIL misalign_xfers got %0d@%h exp 1@2000", obs_xfers, obs_addr[0]); else passes++;
        checks++; if (obs_err !== 1'b1) $display("FAIL misalign_err got %b exp 1", obs_err); else passes++;
        checks++; if (data_readdata !== 32'h0) $display("FAIL misalign_rdata got %h exp 0", data_readdata); else passes++;
        checks++; if (obs_cycles !== 3) $display("FAIL misalign_cycles got %0d exp 3", obs_cycles); else passes++;
        // Both requests high after a good read: only the fetch, error, read data cleared.
        run_step(1'b1, 1'b0, 2'd2, 32'h0, 32'h0, 32'h2004, 32'h24681357, 32'h0, 0);
        run_step(1'b1, 1'b1, 2'd2, 32'h300, 32'h0, 32'h3000, 32'h11112222, 32'h0, 0);
        checks++; if (obs_xfers !== 1 || obs_wr[0] !== 1'b0 || obs_addr[0] !== 32'h3000) $display("FAIL both_xfers got %0d wr=%b @%h exp 1 wr=0 @3000", obs_xfers, obs_wr[0], obs_addr[0]); else passes++;
        checks++; if (obs_err !== 1'b1) $display("FAIL both_err got %b exp 1", obs_err); else passes++;
        checks++; if (data_readdata !== 32'h0) $display("FAIL both_rdata got %h exp 0", data_readdata); else passes++;
        checks++; if (instr_readdata !== 32'h11112222) $display("FAIL both_instr got %h exp 11112222", instr_readdata); else passes++;
        // Dword size is illegal on a 32-bit bus.
        run_step(1'b1, 1'b0, 2'd3, 32'h0, 32'h0, 32'h3004, 32'h0, 32'h0, 0);
        checks++; if (obs_xfers !== 1 || obs_err !== 1'b1) $display("FAIL dword_illegal got xfers=%0d err=%b exp 1/1", obs_xfers, obs_err); else passes++;
        // Misaligned word write is dropped.
        run_step(1'b0, 1'b1, 2'd2, 32'h206, 32'h12345678, 32'h3008, 32'h0, 32'h0, 0);
        checks++; if (obs_xfers !== 1 || obs_wr[0] !== 1'b0 || obs_err !== 1'b1) $display("FAIL misalign_wr got xfers=%0d wr=%b err=%b exp 1/0/1", obs_xfers, obs_wr[0], obs_err); else passes++;
    endtask

    task automatic test_fetch_wait;
        run_step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h2007, 32'hCAFEF00D, 32'h0, FETCH_WAITS);
        checks++; if (obs_cycles !== 3 + FETCH_WAITS) $display("FAIL wait_cycles got %0d exp %0d", obs_cycles, 3 + FETCH_WAITS); else passes++;
        checks++; if (obs_stable !== 1'b1) $display("FAIL wait_stable got %b exp 1", obs_stable); else passes++;
        checks++; if (obs_addr[0] !== 32'h2004 || obs_rd[0] !== 1'b1) $display("FAIL wait_fetch got %h rd=%b exp 2004 rd=1", obs_addr[0], obs_rd[0]); else passes++;
        checks++; if (instr_readdata !== 32'hCAFEF00D) $display("FAIL wait_instr got %h exp cafef00d", instr_readdata); else passes++;
        checks++; if (obs_err !== 1'b0 || obs_ce !== 1) $display("FAIL wait_strobe got err=%b ce=%0d exp 0/1", obs_err, obs_ce); else passes++;
    endtask

    task automatic test_back_to_back;
        run_step(1'b0, 1'b1, 2'd2, 32'h500, 32'h89ABCDEF, 32'h4000, 32'h0, 32'h0, 0);
        checks++; if (obs_wdata[0] !== 32'h89ABCDEF || obs_be[0] !== 4'hF) $display("FAIL b2b_word_wr got %h/%b exp 89abcdef/1111", obs_wdata[0], obs_be[0]); else passes++;
        run_step(1'b0, 1'b1, 2'd1, 32'h506, 32'h0000BEEF, 32'h4004, 32'h0, 32'h0, 0);
        checks++; if (obs_wdata[0] !== 32'hBEEF0000 || obs_be[0] !== 4'b1100 || obs_addr[0] !== 32'h504) $display("FAIL b2b_half_wr got %h/%b@%h exp beef0000/1100@504", obs_wdata[0], obs_be[0], obs_addr[0]); else passes++;
        checks++; if (obs_cycles !== 4 || obs_addr[1] !== 32'h4004) $display("FAIL b2b_cycles got %0d fetch %h exp 4 fetch 4004", obs_cycles, obs_addr[1]); else passes++;
    endtask

    task automatic test_reset_mid;
        data_read = 1'b1; data_write = 1'b0; data_size = 2'd2; data_address = 32'h400;
        instr_address = 32'h5000; av_waitrequest = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (av_read !== 1'b1 || av_address !== 32'h400) $display("FAIL rstmid_before got rd=%b @%h exp rd=1 @400", av_read, av_address); else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (av_read !== 1'b0) $display("FAIL rstmid_av_read got %b exp 0", av_read); else passes++;
        checks++; if (av_address !== 32'h0 || av_byteenable !== 4'h0) $display("FAIL rstmid_bus got %h/%b exp 0/0000", av_address, av_byteenable); else passes++;
        @(negedge clk);
        checks++; if (clk_enable !== 1'b0 || bus_error !== 1'b0) $display("FAIL rstmid_no_step got ce=%b err=%b exp 0/0", clk_enable, bus_error); else passes++;
        av_waitrequest = 1'b0;
        reset_n = 1'b1;
        run_step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h6000, 32'h77778888, 32'h0, 0);
        checks++; if (obs_cycles !== 3 || obs_err !== 1'b0) $display("FAIL rstmid_recover got cycles=%0d err=%b exp 3/0", obs_cycles, obs_err); else passes++;
        checks++; if (instr_readdata !== 32'h77778888) $display("FAIL rstmid_instr got %h exp 77778888", instr_readdata); else passes++;
    endtask

`ifdef AVB_TIMEOUT_EN
    task automatic test_timeout;
        run_step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h7000, 32'h9999, 32'h0, 100);
        checks++; if (obs_cycles !== 6 || obs_xfers !== 0) $display("FAIL tmo_fetch got cycles=%0d xfers=%0d exp 6/0", obs_cycles, obs_xfers); else passes++;
        checks++; if (obs_err !== 1'b1 || instr_readdata !== 32'h0) $display("FAIL tmo_fetch_err got err=%b instr=%h exp 1/0", obs_err, instr_readdata); else passes++;
        run_step(1'b1, 1'b0, 2'd2, 32'h800, 32'h0, 32'h7004, 32'h9999, 32'h0, 100);
        checks++; if (obs_cycles !== 10 || obs_err !== 1'b1) $display("FAIL tmo_data got cycles=%0d err=%b exp 10/1", obs_cycles, obs_err); else passes++;
        checks++; if (data_readdata !== 32'h0) $display("FAIL tmo_data_rdata got %h exp 0", data_readdata); else passes++;
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        reset_n = 1'b1;
        test_word_read;
        test_byte_write;
        test_sized_read;
        test_skipped_access;
        test_fetch_wait;
        test_back_to_back;
        test_reset_mid;
`ifdef AVB_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
